acq_capture_ctrl: RTL and testbench

ACQ_CAPTURE_CTRL -- requirements
Module: acq_capture_ctrl

---
 rtl/acq_capture_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_acq_capture_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_capture_ctrl.sv
// acq_capture_ctrl -- pre/post-trigger capture controller for a circular
// sample RAM.
//
// After an arm pulse the block writes every valid ADC sample into a
// 2^ADDR_W deep RAM. It first collects pre_len pre-trigger samples. It then
// keeps overwriting the ring until a level-crossing or forced trigger
// arrives. Finally it records the remaining N - pre_len samples, counting the
// trigger sample, and parks in DONE until rd_ack is seen.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   adc_data, adc_valid  incoming sample stream
//   arm                  start a capture (IDLE only)
//   trig_level/trig_edge threshold and direction (0 rising, 1 falling)
//   force_trig           software trigger (WAIT_TRIG only)
//   pre_len              number of pre-trigger samples, 0..N-1
//   rd_ack               readout finished, DONE -> IDLE
//   ram_we/waddr/wdata   registered RAM write port
//   busy, done           registered state flags
//   trig_addr            RAM address of the trigger sample
//   start_addr           RAM address of the oldest captured sample
module acq_capture_ctrl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic              rd_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT_TRIG, S_POST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  // Counts up in PRE, and counts the remaining post-trigger samples down in POST.
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic                force_q, force_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_waddr_q, ram_waddr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                edge_hit;
  logic                trig_hit;
  logic                capturing;
  logic [ADDR_W-1:0]   post_rem;

  // N - pre_len - 1 is the bitwise complement of pre_len in ADDR_W bits.
  assign post_rem  = ~pre_len;
  assign capturing = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);

  always_comb begin
    edge_hit = 1'b0;
    if (prev_vld_q) begin
      if (trig_edge) edge_hit = (prev_q >= trig_level) && (adc_data <  trig_level);
      else           edge_hit = (prev_q <  trig_level) && (adc_data >= trig_level);
    end
    trig_hit = adc_valid && (force_q || force_trig || edge_hit);
  end

  // State register (and all datapath flops).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      force_q      <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      force_q      <= force_d;
      ram_we_q     <= ram_we_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (arm) state_d = (pre_len != '0) ? S_PRE : S_WAIT_TRIG;
      S_PRE:       if (adc_valid && (ADDR_W'(cnt_q + 1'b1) == pre_len)) state_d = S_WAIT_TRIG;
      S_WAIT_TRIG: if (trig_hit) state_d = (post_rem == '0) ? S_DONE : S_POST;
      S_POST:      if (adc_valid && (cnt_q == ADDR_W'(1))) state_d = S_DONE;
      S_DONE:      if (rd_ack) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    force_d      = force_q;
    ram_we_d     = 1'b0;
    ram_waddr_d  = ram_waddr_q;
    ram_wdata_d  = ram_wdata_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;

    if ((state_q == S_IDLE) && arm) begin
      ptr_d      = '0;
      cnt_d      = '0;
      prev_vld_d = 1'b0;
      force_d    = 1'b0;
    end

    if (capturing && adc_valid) begin
      ram_we_d    = 1'b1;
      ram_waddr_d = ptr_q;
      ram_wdata_d = adc_data;
      ptr_d       = ptr_q + 1'b1;
      prev_d      = adc_data;
      prev_vld_d  = 1'b1;
    end

    if ((state_q == S_PRE) && adc_valid) cnt_d = cnt_q + 1'b1;

    if (state_q == S_WAIT_TRIG) begin
      if (trig_hit) begin
        trig_addr_d  = ptr_q;
        start_addr_d = ptr_q - pre_len;
        cnt_d        = post_rem;
        force_d      = 1'b0;
      end else if (force_trig) begin
        force_d = 1'b1;
      end
    end

    if ((state_q == S_POST) && adc_valid) cnt_d = cnt_q - 1'b1;

    // Flags are derived from the next state so they line up with state_q.
    busy_d = (state_d == S_PRE) || (state_d == S_WAIT_TRIG) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  assign ram_we     = ram_we_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Testbench for acq_capture_ctrl with N = 16, DATA_W = 12. A behavioural
// model counts samples since arm and post-trigger samples with plain integers.
// It keeps a history queue of every accepted sample. When a capture completes,
// the RAM contents gathered from the write port must hold the last N samples
// in order, starting at start_addr.
module tb_acq_capture_ctrl;
  localparam int DW = 12;
  localparam int AW = 4;
  localparam int N  = 16;

  localparam int M_IDLE = 0;
  localparam int M_PRE  = 1;
  localparam int M_WAIT = 2;
  localparam int M_POST = 3;
  localparam int M_DONE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic          arm;
  logic [DW-1:0] trig_level;
  logic          trig_edge;
  logic          force_trig;
  logic [AW-1:0] pre_len;
  logic          rd_ack;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;

  always #5 clk = ~clk;

  acq_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .arm(arm), .trig_level(trig_level), .trig_edge(trig_edge),
    .force_trig(force_trig), .pre_len(pre_len), .rd_ack(rd_ack),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .trig_addr(trig_addr), .start_addr(start_addr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model state
  int  m_st = M_IDLE;
  int  m_nwr, m_postw, m_prev, m_trig, m_start, e_waddr, e_wdata;
  bit  m_have_prev, m_fpend, e_we, m_just_done;
  int  hist[$];
  int  shadow[N];

  function automatic void model_step();
    int cur;
    int addr;
    int pl;
    bit hit;
    e_we = 1'b0;
    m_just_done = 1'b0;
    pl = int'(pre_len);
    if (!rst) begin
      m_st = M_IDLE; m_nwr = 0; m_postw = 0; m_prev = 0; m_have_prev = 0;
      m_fpend = 0; m_trig = 0; m_start = 0; e_waddr = 0; e_wdata = 0;
      hist.delete();
      return;
    end
    cur = m_st;
    case (cur)
      M_IDLE: if (arm) begin
        m_st = (pl != 0) ? M_PRE : M_WAIT;
        m_nwr = 0; m_postw = 0; m_have_prev = 0; m_fpend = 0;
        hist.delete();
      end
      M_PRE, M_WAIT, M_POST: begin
        if (adc_valid) begin
          addr = m_nwr % N;
          e_we = 1'b1; e_waddr = addr; e_wdata = int'(adc_data);
          m_nwr++;
          hist.push_back(int'(adc_data));
          if (cur == M_PRE && m_nwr == pl) m_st = M_WAIT;
          if (cur == M_WAIT) begin
            hit = m_fpend || force_trig ||
                  (m_have_prev && (trig_edge ?
                     (m_prev >= int'(trig_level) && int'(adc_data) <  int'(trig_level)) :
                     (m_prev <  int'(trig_level) && int'(adc_data) >= int'(trig_level))));
            if (hit) begin
              m_trig = addr;
              m_start = (addr - pl + N) % N;
              m_postw = 1;
              m_fpend = 0;
              m_st = (m_postw == N - pl) ? M_DONE : M_POST;
            end else if (force_trig) m_fpend = 1;
          end
          if (cur == M_POST) begin
            m_postw++;
            if (m_postw == N - pl) m_st = M_DONE;
          end
          m_prev = int'(adc_data);
          m_have_prev = 1;
        end else if (cur == M_WAIT && force_trig) m_fpend = 1;
      end
      M_DONE: if (rd_ack) m_st = M_IDLE;
      default: m_st = M_IDLE;
    endcase
    if (m_st == M_DONE && cur != M_DONE) m_just_done = 1'b1;
  endfunction

  // One clock: model consumes the inputs, then outputs are compared on the
  // following falling edge. Pulse inputs are dropped after each cycle.
  task automatic tick();
    int base;
    model_step();
    @(negedge clk);
    arm = 1'b0; force_trig = 1'b0; rd_ack = 1'b0;
    chk("ram_we", ram_we, e_we);
    if (e_we) begin
      chk("ram_waddr", ram_waddr, e_waddr);
      chk("ram_wdata", ram_wdata, e_wdata);
    end
    if (ram_we) shadow[ram_waddr] = int'(ram_wdata);
    chk("busy", busy, (m_st == M_PRE || m_st == M_WAIT || m_st == M_POST));
    chk("done", done, (m_st == M_DONE));
    chk("trig_addr", trig_addr, m_trig);
    chk("start_addr", start_addr, m_start);
    if (m_just_done && hist.size() >= N) begin
      base = hist.size() - N;
      for (int i = 0; i < N; i++)
        chk("ram_content", shadow[(m_start + i) % N], hist[base + i]);
    end
  endtask

  task automatic smp(input bit v, input int d);
    adc_valid = v;
    adc_data  = DW'(d);
    tick();
  endtask

  initial begin
    int lim;
    rst = 1'b0; adc_data = '0; adc_valid = 1'b0; arm = 1'b0; trig_level = '0;
    trig_edge = 1'b0; force_trig = 1'b0; pre_len = '0; rd_ack = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Rising ramp with 4 pre-trigger samples
    pre_len = 4; trig_edge = 1'b0; trig_level = 100; arm = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      smp(1'b1, i * 10);
      if (m_st == M_DONE) break;
    end
    chk("ramp_done", done, 1);
    chk("ramp_trig_addr", trig_addr, 10);
    chk("ramp_start_addr", start_addr, 6);
    rd_ack = 1'b1; smp(1'b0, 0);

    // Falling edge, no pre-trigger, pointer wraps
    pre_len = 0; trig_edge = 1'b1; trig_level = 50; arm = 1'b1;
    tick();
    smp(1'b1, 80); smp(1'b1, 60); smp(1'b1, 40);
    for (int i = 0; i < 20; i++) begin
      if (m_st == M_DONE) break;
      smp(1'b1, 40);
    end
    chk("fall_trig_addr", trig_addr, 2);
    chk("fall_start_addr", start_addr, 2);
    rd_ack = 1'b1; smp(1'b0, 0);

    // Force trigger pulse without a valid sample, sample follows next cycle
    pre_len = 3; trig_edge = 1'b0; trig_level = 100; arm = 1'b1;
    tick();
    repeat (5) smp(1'b1, 0);
    force_trig = 1'b1; smp(1'b0, 0);
    smp(1'b1, 0);
    chk("force_trig_addr", trig_addr, 5);
    chk("force_start_addr", start_addr, 2);
    for (int i = 0; i < 20; i++) begin
      if (m_st == M_DONE) break;
      smp(1'b1, 0);
    end
    chk("force_done", done, 1);
    rd_ack = 1'b1; smp(1'b0, 0);

    // pre_len = N-1: crossing during PRE ignored, trigger goes straight to DONE
    pre_len = 15; trig_edge = 1'b0; trig_level = 50; arm = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) smp(1'b1, i * 10);
    chk("pre_cross_busy", busy, 1);
    smp(1'b1, 0);
    smp(1'b1, 100);
    chk("full_pre_done", done, 1);
    chk("full_pre_trig_addr", trig_addr, 0);
    chk("full_pre_start_addr", start_addr, 1);

    // Reset in the middle of POST, then restart
    rd_ack = 1'b1; smp(1'b0, 0);
    pre_len = 2; trig_level = 100; arm = 1'b1;
    tick();
    smp(1'b1, 1); smp(1'b1, 2);
    force_trig = 1'b1; smp(1'b1, 3);
    smp(1'b1, 4); smp(1'b1, 5);
    rst = 1'b0; smp(1'b1, 6);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trig_addr", trig_addr, 0);
    rst = 1'b1; arm = 1'b1; smp(1'b0, 0);
    smp(1'b1, 7);
    chk("restart_waddr", ram_waddr, 0);
    for (int i = 0; i < 30; i++) begin
      if (m_st == M_DONE) break;
      force_trig = 1'b1;
      smp(1'b1, 8 + i);
    end

    // DONE with arm and rd_ack together: no capture; arm next cycle starts one
    arm = 1'b1; rd_ack = 1'b1; smp(1'b0, 0);
    chk("ack_arm_busy", busy, 0);
    arm = 1'b1; smp(1'b0, 0);
    chk("rearm_busy", busy, 1);
    for (int i = 0; i < 60; i++) begin
      if (m_st == M_DONE) break;
      force_trig = (i > 20);
      smp(1'b1, i);
    end
    rd_ack = 1'b1; smp(1'b0, 0);

    // Randomized captures
    for (int k = 0; k < 25; k++) begin
      pre_len    = AW'($urandom_range(0, N - 1));
      trig_edge  = 1'($urandom_range(0, 1));
      trig_level = DW'($urandom_range(0, 4095));
      arm = 1'b1;
      tick();
      lim = 0;
      while (lim < 300 && m_st != M_DONE && m_st != M_IDLE) begin
        arm        = ($urandom_range(0, 49) == 0);
        force_trig = ($urandom_range(0, 39) == 0);
        rd_ack     = ($urandom_range(0, 29) == 0);
        rst        = ($urandom_range(0, 399) != 0);
        smp($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)));
        rst = 1'b1;
        lim++;
      end
      repeat ($urandom_range(0, 3)) begin
        arm = ($urandom_range(0, 1) == 1);
        smp($urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)));
      end
      rd_ack = 1'b1;
      smp(1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
